// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: first-word-fall-through receive FIFO with a sticky overrun flag
//   clk_i           rising-edge clock
//   rst_i           synchronous active-low reset (pointers and overrun only)
//   char_i          character from character_recovery
//   char_valid_i    write strobe; dropped and flagged when full without a pop
//   data_o/valid_o  head of FIFO, valid while non-empty
//   ready_i         consumer accepts head when high with valid_o
//   level_o         stored character count, 0..DEPTH
//   overrun_o       sticky drop flag; overrun_clear_i clears it, a drop wins
module uart_rx_buffer #(
    parameter  int DATA_BITS = 8,
    parameter  int DEPTH     = 16,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] char_i,
    input  logic                 char_valid_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ADDR_BITS:0]   level_o,
    output logic                 overrun_o,
    input  logic                 overrun_clear_i
);
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS:0]   wr_ptr, rd_ptr;
    logic                 full, push, pop;
    // Extra pointer MSB tells full from empty when the low bits match
    assign full    = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                     (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign valid_o = wr_ptr != rd_ptr;
    assign pop     = valid_o && ready_i;
    assign push    = char_valid_i && (!full || pop);
    assign level_o = wr_ptr - rd_ptr;
    assign data_o  = mem[rd_ptr[ADDR_BITS-1:0]];
    always_ff @(posedge clk_i)
        if (push)
            mem[wr_ptr[ADDR_BITS-1:0]] <= char_i;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            overrun_o <= (char_valid_i && full && !pop) ? 1'b1 :
                         overrun_clear_i ? 1'b0 : overrun_o;
        end
    end
endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side character FIFO sitting directly downstream of `character_recovery` in the UART-lite receive path. It captures each single-cycle `valid` strobe and its recovered character, stores up to `DEPTH` characters, and presents them to the host side through a first-word-fall-through valid/ready interface. When a character arrives while the FIFO is full, the block drops that character and sets a sticky overrun flag.

## Interface
- `DATA_BITS`, default 8: character width; must match `character_recovery` `DATA_BITS`.
- `DEPTH`, default 16: storage entries; power of two, ≥ 2. `ADDR_BITS = $clog2(DEPTH)` is derived internally.
- `clk_i`  in  1  sole clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `char_i`  in  DATA_BITS  character from `character_recovery.char_o`.
- `char_valid_i`  in  1  write strobe from `character_recovery.valid_o`; the block accepts any pulse width and spacing.
- `data_o`  out  DATA_BITS  head-of-FIFO character.
- `valid_o`  out  1  FIFO non-empty; `data_o` is meaningful.
- `ready_i`  in  1  consumer accepts the head when it is high together with `valid_o`.
- `level_o`  out  ADDR_BITS+1  number of stored characters, 0..DEPTH.
- `overrun_o`  out  1  sticky: at least one character was dropped.
- `overrun_clear_i`  in  1  clears `overrun_o`.

## Operation
- **Storage:** `DEPTH` × `DATA_BITS` array; memory is not reset.
- **Pointers:** `wr_ptr` and `rd_ptr`, each ADDR_BITS+1 bits wide, wrapping modulo 2^(ADDR_BITS+1). The array index is the low ADDR_BITS bits.
  - Empty: `wr_ptr == rd_ptr`.
  - Full: MSBs differ and low bits are equal.
  - `level_o = wr_ptr - rd_ptr`, truncated to ADDR_BITS+1 bits.
- **Push:** `push = char_valid_i && (!full || pop)`. On push, write `mem[wr_ptr] <= char_i` and increment `wr_ptr`.
- **Pop:** `pop = valid_o && ready_i`. On pop, increment `rd_ptr`. `ready_i` is ignored while empty.
- **Full with simultaneous pop:** push is accepted; level stays at DEPTH.
- **Full without pop:** if `char_valid_i` is high, the character is discarded, pointers are unchanged, and `overrun_o <= 1`.
- **Overrun clear:** `overrun_clear_i` clears `overrun_o` on the next edge. If a drop happens in the same cycle, set wins and `overrun_o` stays 1.
- **Empty with push and `ready_i` high:** no bypass. The push is stored and no pop occurs.
- **Output path:** `valid_o = !empty`. `data_o = mem[rd_ptr[ADDR_BITS-1:0]]`, a combinational read from the registered pointer.
  - `data_o` holds stable while `valid_o && !ready_i`.
  - `data_o` is don't-care while `valid_o = 0`.
- **Reset** (`rst_i == 0` at an edge): `wr_ptr = rd_ptr = 0`, `overrun_o = 0`. Reset overrides push, pop and clear in the same cycle, and contents are discarded even mid-stream.
- **Control state:** there is no FSM beyond the pointer pair and the overrun bit. All three are updated in one `always @(posedge clk_i)` block.

## Timing
- **Outputs after reset:** `valid_o = 0`, `level_o = 0`, `overrun_o = 0`, `data_o` undefined.
- **Write-to-output latency:** 1 cycle. Strobe at edge N gives `valid_o = 1` and `data_o = char_i` after edge N, visible in cycle N+1.
- **Pop:** the next entry (or `valid_o = 0`) appears the cycle after the pop edge.
- **Level:** `level_o` updates on the same edge as the pointers. Push+pop in one cycle leaves it unchanged.
- **Overrun:** `overrun_o` rises in the cycle after the dropped strobe.
- **Throughput:** sustains one push and one pop per cycle; no combinational path from `char_valid_i` to `valid_o`.

## Test plan
- **Reset then idle:** `rst_i = 0` for 2 cycles, release → `valid_o = 0`, `level_o = 0`, `overrun_o = 0` for 10 cycles.
- **Single character:** strobe `char_i = 8'hA5` once → next cycle `valid_o = 1`, `data_o = 8'hA5`, `level_o = 1`. Hold `ready_i = 0` for 5 cycles → `data_o` unchanged. Pulse `ready_i` → `valid_o = 0`, `level_o = 0`.
- **Fill and overrun** (DEPTH = 16): push 8'h00..8'h0F with `ready_i = 0` → `level_o = 16`. Push 8'hFF → dropped, `overrun_o = 1`. Drain → reads 8'h00..8'h0F in order, never 8'hFF.
- **Full with simultaneous push/pop:** at level 16, strobe 8'h55 with `ready_i = 1` → `level_o` stays 16, `overrun_o` stays 0, and 8'h55 is read last.
- **Overrun clear race:** with the FIFO full, assert `overrun_clear_i` together with a strobe → `overrun_o = 1`. Clear alone → `overrun_o = 0` next cycle.
- **Wrap-around and mid-stream reset:**
  - Stream 40 characters (0..39), each strobe followed 160 cycles later by a read → all 40 returned in order across pointer wrap.
  - Then push 3 characters and assert reset → `level_o = 0`, `valid_o = 0`, and the next read returns only post-reset data.
